wts_channel_mixer: RTL
======================

# wts_channel_mixer

Downstream consumer of the per-channel tone generators in the wave table sound core. On each 3.579 MHz `active` pulse it snapshots every channel's wave memory address, volume and enable, then reads one signed 8-bit sample per channel from the shared wave RAM. It scales each sample by its 4-bit volume and accumulates the channels into one signed mix sample for the output stage.

## Interface
Parameters:
- `CHANNELS`, default 5: number of tone channels; legal range 2..8.
- `OUT_W`, default 12 + $clog2(CHANNELS) (15 at default): mix output width.

Ports:
- `clk`  in  1  system clock.
- `nreset`  in  1  reset, asynchronous, active-low.
- `active`  in  1  3.579 MHz timing pulse, one `clk` wide.
- `ch_wave_address`  in  7*CHANNELS  channel k address at bits [7k+6:7k], from the tone generators.
- `reg_volume`  in  4*CHANNELS  unsigned volume 0..15 per channel.
- `reg_enable`  in  CHANNELS  per-channel enable.
- `sram_rd`  out  1  wave RAM read strobe.
- `sram_address`  out  3+7  {channel index[2:0], wave address[6:0]}.
- `sram_rdata`  in  8  signed sample, valid exactly 1 `clk` after `sram_rd`.
- `mix_out`  out  OUT_W  signed mixed sample; holds between updates.
- `mix_valid`  out  1  one-`clk` pulse when `mix_out` updates.
- `overrun`  out  1  one-`clk` pulse when `active` arrives while busy.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE with `active`=1:
  - latch all addresses, volumes and enables into snapshot registers;
  - clear the accumulator and the channel counter;
  - go to ISSUE.
- ISSUE:
  - drive `sram_rd`=1 and `sram_address`={k, addr_k} for k = 0..CHANNELS-1, one channel per cycle;
  - after channel CHANNELS-1, go to DRAIN.
- Pipeline: the sample returned in a cycle belongs to the channel issued in the previous cycle. Product = signed(`sram_rdata`) × {1'b0, volume}, 12-bit signed, range -1920..+1905.
- Disabled channel: the read is still issued, so timing stays fixed, but its product is forced to 0.
- Accumulator: OUT_W signed, adds sign-extended products. No saturation needed; worst case ±CHANNELS×1920 fits OUT_W.
- DRAIN: accumulate the last channel's product, load `mix_out` with the final sum, go to OUTPUT.
- OUTPUT: `mix_valid`=1 for this cycle only, then return to IDLE. `active` arriving in this cycle is treated as overrun.
- `active` seen in any state other than IDLE is ignored and pulses `overrun`; the mix in progress is unaffected.
- Inputs that change after the snapshot do not affect the mix in progress.

## Timing
- `active` sampled high at edge T.
- `sram_rd` is high in cycles T+1..T+CHANNELS; address for channel k is driven in cycle T+1+k.
- `mix_out` is updated at the edge ending cycle T+1+CHANNELS. `mix_valid` is high in cycle T+2+CHANNELS, a latency of CHANNELS+2 clocks (7 at default).
- Required minimum `active` spacing: CHANNELS+3 clocks. Closer spacing produces `overrun`.
- Reset values: `mix_out`=0, `mix_valid`=0, `overrun`=0, `sram_rd`=0, `sram_address`=0, FSM=IDLE, accumulator=0.
- Reset asserted mid-mix: abort immediately, no `mix_valid`, and `mix_out` returns to 0.
- `sram_rd`=0 means `sram_address` holds its last value. `sram_rdata` is ignored outside the pipeline slots.

## Structure
- Shared package `wts_pkg` holds:
  - WAVE_ADDR_W=7, SAMPLE_W=8, VOLUME_W=4, PRODUCT_W=12, CH_INDEX_W=3;
  - the FSM state encoding.
- Sub-module `wts_volume_scaler`: combinational signed 8 × unsigned 4 → signed 12, gated by enable. It is reused by future per-channel stages.
- Top level contains the FSM, channel counter, snapshot registers, accumulator and output registers.

## Test plan
- All channels enabled, volume 15, RAM returns 0x7F → `mix_out`=9525, `mix_valid` 7 clocks after `active`.
- All channels enabled, volume 15, RAM returns 0x80 → `mix_out`=-9600.
- Channel k sample = 0x10×(k+1), volume 1, channel 2 disabled → `mix_out`=0x10+0x20+0x40+0x50=192. Addresses {k, addr_k} are issued in order 0..4.
- Second `active` 4 clocks after the first → one `overrun` pulse, a single `mix_valid`, and the first mix value is correct.
- `nreset` pulsed during ISSUE → `sram_rd`=0 and `mix_out`=0 immediately. The next `active` produces a correct mix.
- Volume and address inputs changed one clock after `active` → the result reflects only the snapshot values.

Source files
------------

// File: rtl/wts_pkg.sv
// Shared definitions for the wave table sound core.
//
// Holds the common datapath widths used by the channel stages and the
// state encoding of the channel mixer sequencer.
package wts_pkg;

    localparam int WAVE_ADDR_W = 7;   // wave RAM address per channel
    localparam int SAMPLE_W    = 8;   // signed wave sample
    localparam int VOLUME_W    = 4;   // unsigned channel volume
    localparam int PRODUCT_W   = 12;  // signed sample x volume
    localparam int CH_INDEX_W  = 3;   // channel index (up to 8 channels)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/wts_volume_scaler.sv
// Combinational volume stage: signed sample times unsigned volume.
//
// Ports:
//   sample  in  SAMPLE_W   signed wave sample
//   volume  in  VOLUME_W   unsigned volume 0..15
//   enable  in  1          channel enable; product forced to 0 when low
//   product out PRODUCT_W  signed product, range -1920..+1905
module wts_volume_scaler
    import wts_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0]  sample,
    input  logic        [VOLUME_W-1:0]  volume,
    input  logic                        enable,
    output logic signed [PRODUCT_W-1:0] product
);

    // One spare bit so the zero-extended volume multiplies as signed.
    logic signed [SAMPLE_W+VOLUME_W:0] full_product;

    always_comb begin
        full_product = sample * $signed({1'b0, volume});
        product      = enable ? full_product[PRODUCT_W-1:0] : '0;
    end

endmodule

// File: rtl/wts_channel_mixer.sv
// Channel mixer: on each active pulse, snapshot every channel's wave
// address, volume and enable, read one sample per channel from the shared
// wave RAM, scale by volume and sum into one signed mix sample.
//
// Ports:
//   clk              in   system clock
//   nreset           in   asynchronous active-low reset
//   active           in   one-clk timing pulse that starts a mix
//   ch_wave_address  in   7 bits per channel, channel k at [7k+6:7k]
//   reg_volume       in   4 bits per channel
//   reg_enable       in   1 bit per channel
//   sram_rd          out  wave RAM read strobe
//   sram_address     out  {channel index, wave address}
//   sram_rdata       in   signed sample, valid 1 clk after sram_rd
//   mix_out          out  signed mix, holds between updates
//   mix_valid        out  one-clk pulse after mix_out updates
//   overrun          out  one-clk pulse when active arrives while busy
module wts_channel_mixer
    import wts_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int OUT_W    = 12 + $clog2(CHANNELS)
) (
    input  logic                                clk,
    input  logic                                nreset,
    input  logic                                active,
    input  logic [WAVE_ADDR_W*CHANNELS-1:0]     ch_wave_address,
    input  logic [VOLUME_W*CHANNELS-1:0]        reg_volume,
    input  logic [CHANNELS-1:0]                 reg_enable,
    output logic                                sram_rd,
    output logic [CH_INDEX_W+WAVE_ADDR_W-1:0]   sram_address,
    input  logic [SAMPLE_W-1:0]                 sram_rdata,
    output logic signed [OUT_W-1:0]             mix_out,
    output logic                                mix_valid,
    output logic                                overrun
);

    localparam logic [CH_INDEX_W-1:0] LAST_CH = CH_INDEX_W'(CHANNELS - 1);

    state_t                              state_q, state_d;
    logic [CH_INDEX_W-1:0]               cnt_q, cnt_d;
    logic [WAVE_ADDR_W*CHANNELS-1:0]     snap_addr_q, snap_addr_d;
    logic [VOLUME_W*CHANNELS-1:0]        snap_vol_q, snap_vol_d;
    logic [CHANNELS-1:0]                 snap_en_q, snap_en_d;
    logic signed [OUT_W-1:0]             acc_q, acc_d;
    logic signed [OUT_W-1:0]             mix_q, mix_d;
    logic                                rd_q, rd_d;
    logic [CH_INDEX_W+WAVE_ADDR_W-1:0]   addr_q, addr_d;
    logic                                ovr_q, ovr_d;

    // The sample arriving now belongs to the channel issued last cycle:
    // cnt-1 while issuing, the last channel while draining.
    logic [CH_INDEX_W-1:0]               prod_idx;
    logic [CH_INDEX_W-1:0]               next_idx;
    logic signed [PRODUCT_W-1:0]         product;
    logic signed [OUT_W-1:0]             product_ext;

    always_comb begin
        prod_idx = (state_q == ST_DRAIN) ? LAST_CH : cnt_q - 1'b1;
        // Saturate at the last channel so the part select never leaves range.
        next_idx = (cnt_q == LAST_CH) ? cnt_q : cnt_q + 1'b1;
    end

    wts_volume_scaler u_scaler (
        .sample  ($signed(sram_rdata)),
        .volume  (snap_vol_q[prod_idx*VOLUME_W +: VOLUME_W]),
        .enable  (snap_en_q[prod_idx]),
        .product (product)
    );

    assign product_ext = {{(OUT_W-PRODUCT_W){product[PRODUCT_W-1]}}, product};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_addr_d = snap_addr_q;
        snap_vol_d  = snap_vol_q;
        snap_en_d   = snap_en_q;
        acc_d       = acc_q;
        mix_d       = mix_q;
        rd_d        = 1'b0;
        addr_d      = addr_q;
        ovr_d       = active && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    snap_addr_d = ch_wave_address;
                    snap_vol_d  = reg_volume;
                    snap_en_d   = reg_enable;
                    acc_d       = '0;
                    cnt_d       = '0;
                    // Channel 0 is issued straight from the live inputs,
                    // which equal the values being snapshotted this edge.
                    rd_d        = 1'b1;
                    addr_d      = {CH_INDEX_W'(0), ch_wave_address[WAVE_ADDR_W-1:0]};
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q != '0) begin
                    acc_d = acc_q + product_ext;
                end
                if (cnt_q == LAST_CH) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d  = next_idx;
                    rd_d   = 1'b1;
                    addr_d = {next_idx, snap_addr_q[next_idx*WAVE_ADDR_W +: WAVE_ADDR_W]};
                end
            end
            ST_DRAIN: begin
                mix_d   = acc_q + product_ext;
                state_d = ST_OUTPUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            snap_addr_q <= '0;
            snap_vol_q  <= '0;
            snap_en_q   <= '0;
            acc_q       <= '0;
            mix_q       <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_addr_q <= snap_addr_d;
            snap_vol_q  <= snap_vol_d;
            snap_en_q   <= snap_en_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign sram_rd      = rd_q;
    assign sram_address = addr_q;
    assign mix_out      = mix_q;
    assign mix_valid    = (state_q == ST_OUTPUT);
    assign overrun      = ovr_q;

endmodule
